divider_unit: RTL and testbench

- Parametrised fractional restoring divider for the math-box CPU bus.
- Successor to the fixed 16-bit, two-clocks-per-bit divider, adding:
  - configurable operand width and step rate;
  - busy/done/divide-by-zero status;
  - residue readback;
  - a divisor snapshot at start, so mid-run divisor writes cannot corrupt a result;
  - restart on re-trigger.
- Sits beside the math-box sequencer; the CPU writes operands and reads results through one byte-wide register window.

---
 rtl/math_box_pkg.sv | 27 ++
 rtl/divider_unit_if.sv | 31 +++
 rtl/divider_unit_div_step.sv | 29 ++
 rtl/divider_unit.sv | 158 +++++++++++++++
 tb/tb_divider_unit.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/math_box_pkg.sv
// Shared definitions for the math-box divider: register window layout,
// control states and the address-width derivation.
package math_box_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Address bits needed to cover dividend, divisor and status bytes.
    function automatic int aw_of(input int b);
        return $clog2(2 * b + 1);
    endfunction

    function automatic int dividend_base();
        return 0;
    endfunction

    function automatic int divisor_base(input int b);
        return b;
    endfunction

    function automatic int status_addr(input int b);
        return 2 * b;
    endfunction

endpackage

// File: rtl/divider_unit_if.sv
// CPU byte-window bus between the math-box sequencer and the divider.
interface divider_unit_if #(
    parameter int WIDTH = 16
);
    import math_box_pkg::*;

    localparam int AW = aw_of(WIDTH / 8);

    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [7:0]    cpu_data_in;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;

    modport master (
        output wr_en,
        output wr_addr,
        output cpu_data_in,
        output rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en,
        input  wr_addr,
        input  cpu_data_in,
        input  rd_addr,
        output rd_data
    );

endinterface

// File: rtl/divider_unit_div_step.sv
// One restoring-division step: trial subtract, then shift either the
// difference or the untouched dividend, filling the LSB on a miss.
module div_step #(
    parameter int WIDTH    = 16,
    parameter int ONE_FILL = 1
) (
    input  logic [WIDTH-1:0] dvd_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] dvd_o,
    output logic             carry_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] fill;

    assign fill = {{(WIDTH-1){1'b0}}, (ONE_FILL != 0)};

    // Trial subtract via two's complement; carry out means dvd >= div.
    always_comb begin
        sum     = {1'b0, dvd_i} + {1'b0, ~div_i} + {{WIDTH{1'b0}}, 1'b1};
        carry_o = sum[WIDTH];
        if (carry_o) begin
            dvd_o = sum[WIDTH-1:0] << 1;
        end else begin
            dvd_o = (dvd_i << 1) | fill;
        end
    end

endmodule

// File: rtl/divider_unit.sv
// Fractional restoring divider with a byte-wide CPU register window.
// The divisor is snapshotted at start so later window writes only
// affect the next division.
module divider_unit
    import math_box_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int STEP_DIV = 2,
    parameter int ONE_FILL = 1
) (
    input  logic             clk_6,
    input  logic             reset,
    divider_unit_if.slave    bus,
    output logic [WIDTH-1:0] quotient,
    output logic             busy,
    output logic             done,
    output logic             div_zero
);

    localparam int B  = WIDTH / 8;
    localparam int AW = aw_of(B);
    localparam int PW = 2;
    localparam int SW = $clog2(WIDTH) + 1;

    localparam logic [0:0]    S_IDLE  = 1'(IDLE);
    localparam logic [0:0]    S_RUN   = 1'(RUN);
    localparam logic [AW-1:0] A_START = AW'(dividend_base());
    localparam logic [AW-1:0] A_STAT  = AW'(status_addr(B));
    localparam logic [PW-1:0] PH_LAST = PW'(STEP_DIV - 1);
    localparam logic [SW-1:0] ST_LAST = SW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [PW-1:0]    phase_q, phase_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] dividend_q, dividend_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;
    logic [WIDTH-1:0] step_dvd;
    logic             step_carry;
    logic             start;

    div_step #(
        .WIDTH    (WIDTH),
        .ONE_FILL (ONE_FILL)
    ) u_div_step (
        .dvd_i   (dvd_q),
        .div_i   (snap_q),
        .dvd_o   (step_dvd),
        .carry_o (step_carry)
    );

    assign start = bus.wr_en && (bus.wr_addr == A_START);

    // Byte-lane updates of the dividend and divisor operand registers.
    always_comb begin
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        for (int i = 0; i < B; i++) begin
            if (bus.wr_en && bus.wr_addr == AW'(dividend_base() + i)) begin
                dividend_d[i*8 +: 8] = bus.cpu_data_in;
            end
            if (bus.wr_en && bus.wr_addr == AW'(divisor_base(B) + i)) begin
                divisor_d[i*8 +: 8] = bus.cpu_data_in;
            end
        end
    end

    // Start/restart, phase pacing and one step per STEP_DIV clocks.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        step_d  = step_q;
        snap_d  = snap_q;
        dvd_d   = dvd_q;
        quot_d  = quot_q;
        done_d  = done_q;
        dz_d    = dz_q;
        if (start) begin
            // The low byte comes straight off the bus since it lands this edge.
            state_d = S_RUN;
            phase_d = '0;
            step_d  = '0;
            quot_d  = '0;
            done_d  = 1'b0;
            dz_d    = (divisor_q == '0);
            snap_d  = divisor_q;
            dvd_d   = {dividend_q[WIDTH-1:8], bus.cpu_data_in};
        end else if (state_q == S_RUN) begin
            if (phase_q == PH_LAST) begin
                phase_d = '0;
                dvd_d   = step_dvd;
                quot_d  = {quot_q[WIDTH-2:0], step_carry};
                if (step_q == ST_LAST) begin
                    state_d = S_IDLE;
                    step_d  = '0;
                    done_d  = 1'b1;
                end else begin
                    step_d = step_q + SW'(1);
                end
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge clk_6 or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            step_q     <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            snap_q     <= '0;
            dvd_q      <= '0;
            quot_q     <= '0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            step_q     <= step_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            snap_q     <= snap_d;
            dvd_q      <= dvd_d;
            quot_q     <= quot_d;
            done_q     <= done_d;
            dz_q       <= dz_d;
        end
    end

    // Combinational read window: quotient, residue, then status.
    always_comb begin
        bus.rd_data = 8'h00;
        for (int i = 0; i < B; i++) begin
            if (bus.rd_addr == AW'(i)) begin
                bus.rd_data = quot_q[i*8 +: 8];
            end
            if (bus.rd_addr == AW'(B + i)) begin
                bus.rd_data = dvd_q[i*8 +: 8];
            end
        end
        if (bus.rd_addr == A_STAT) begin
            bus.rd_data = {5'b0, dz_q, done_q, (state_q == S_RUN)};
        end
    end

    assign quotient = quot_q;
    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule

// File: tb/tb_divider_unit.sv
// Directed bench for divider_unit at three parameter points.
// Expected quotients/residues follow the step rule including the one-fill,
// which can let the residue climb back above the divisor in late steps.
module tb_divider_unit;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    divider_unit_if #(.WIDTH(16)) b16 ();
    divider_unit_if #(.WIDTH(8))  b8  ();
    divider_unit_if #(.WIDTH(32)) b32 ();

    logic [15:0] q16;
    logic [7:0]  q8;
    logic [31:0] q32;
    logic        busy16, done16, dz16;
    logic        busy8, done8, dz8;
    logic        busy32, done32, dz32;
    logic [7:0]  rd;

    divider_unit #(.WIDTH(16), .STEP_DIV(2), .ONE_FILL(1)) dut16 (
        .clk_6(clk), .reset(rst), .bus(b16),
        .quotient(q16), .busy(busy16), .done(done16), .div_zero(dz16)
    );
    divider_unit #(.WIDTH(8), .STEP_DIV(1), .ONE_FILL(0)) dut8 (
        .clk_6(clk), .reset(rst), .bus(b8),
        .quotient(q8), .busy(busy8), .done(done8), .div_zero(dz8)
    );
    divider_unit #(.WIDTH(32), .STEP_DIV(4), .ONE_FILL(1)) dut32 (
        .clk_6(clk), .reset(rst), .bus(b32),
        .quotient(q32), .busy(busy32), .done(done32), .div_zero(dz32)
    );

    // Each write is presented just after a falling edge and captured on the next rising edge.
    task automatic wr16(input logic [2:0] a, input logic [7:0] d);
        b16.wr_addr = a; b16.cpu_data_in = d; b16.wr_en = 1'b1;
        @(negedge clk);
        b16.wr_en = 1'b0;
    endtask

    task automatic wr8(input logic [1:0] a, input logic [7:0] d);
        b8.wr_addr = a; b8.cpu_data_in = d; b8.wr_en = 1'b1;
        @(negedge clk);
        b8.wr_en = 1'b0;
    endtask

    task automatic wr32(input logic [3:0] a, input logic [7:0] d);
        b32.wr_addr = a; b32.cpu_data_in = d; b32.wr_en = 1'b1;
        @(negedge clk);
        b32.wr_en = 1'b0;
    endtask

    task automatic rd16(input logic [2:0] a, output logic [7:0] d);
        b16.rd_addr = a;
        #1;
        d = b16.rd_data;
    endtask

    task automatic test_reset;
        n_checks++; if (q16 !== 16'h0) begin n_fail++; $display("FAIL reset_q16: got %h want 0000", q16); end
        n_checks++; if ({busy16, done16, dz16} !== 3'b000) begin n_fail++; $display("FAIL reset_flags16: got %b want 000", {busy16, done16, dz16}); end
        rd16(3'd4, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL reset_status16: got %h want 00", rd); end
        n_checks++; if (q8 !== 8'h0 || q32 !== 32'h0) begin n_fail++; $display("FAIL reset_q8_q32: got %h %h want 0 0", q8, q32); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        wr16(3'd2, 8'h00); wr16(3'd3, 8'h80); wr16(3'd1, 8'h40); wr16(3'd0, 8'h00);
        n_checks++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b want 1", busy16); end
        repeat (31) @(negedge clk);
        n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b1) begin n_fail++; $display("FAIL basic_early: done %b busy %b want 0 1", done16, busy16); end
        @(negedge clk);
        n_checks++; if (done16 !== 1'b1 || busy16 !== 1'b0) begin n_fail++; $display("FAIL basic_done: done %b busy %b want 1 0", done16, busy16); end
        n_checks++; if (q16 !== 16'h4000) begin n_fail++; $display("FAIL basic_quot: got %h want 4000", q16); end
        n_checks++; if (dz16 !== 1'b0) begin n_fail++; $display("FAIL basic_dz: got %b want 0", dz16); end
        rd16(3'd0, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL basic_rd0: got %h want 00", rd); end
        rd16(3'd1, rd);
        n_checks++; if (rd !== 8'h40) begin n_fail++; $display("FAIL basic_rd1: got %h want 40", rd); end
        @(negedge clk);
    endtask

    task automatic test_equal;
        wr16(3'd2, 8'h34); wr16(3'd3, 8'h12); wr16(3'd1, 8'h12); wr16(3'd0, 8'h34);
        repeat (32) @(negedge clk);
        n_checks++; if (q16 !== 16'h8003) begin n_fail++; $display("FAIL equal_quot: got %h want 8003", q16); end
        rd16(3'd2, rd);
        n_checks++; if (rd !== 8'hC4) begin n_fail++; $display("FAIL equal_res_lo: got %h want c4", rd); end
        rd16(3'd3, rd);
        n_checks++; if (rd !== 8'h12) begin n_fail++; $display("FAIL equal_res_hi: got %h want 12", rd); end
        rd16(3'd4, rd);
        n_checks++; if (rd !== 8'h02) begin n_fail++; $display("FAIL equal_status: got %h want 02", rd); end
        @(negedge clk);
    endtask

    task automatic test_div_zero;
        wr16(3'd2, 8'h00); wr16(3'd3, 8'h00); wr16(3'd1, 8'h00); wr16(3'd0, 8'h01);
        n_checks++; if (dz16 !== 1'b1 || done16 !== 1'b0) begin n_fail++; $display("FAIL dz_start: dz %b done %b want 1 0", dz16, done16); end
        repeat (32) @(negedge clk);
        n_checks++; if (q16 !== 16'hFFFF) begin n_fail++; $display("FAIL dz_quot: got %h want ffff", q16); end
        rd16(3'd4, rd);
        n_checks++; if (rd !== 8'h06) begin n_fail++; $display("FAIL dz_status: got %h want 06", rd); end
        @(negedge clk);
    endtask

    task automatic test_snapshot;
        wr16(3'd2, 8'h00); wr16(3'd3, 8'h80); wr16(3'd1, 8'h40); wr16(3'd0, 8'h00);
        n_checks++; if (done16 !== 1'b0 || dz16 !== 1'b0) begin n_fail++; $display("FAIL snap_clear: done %b dz %b want 0 0", done16, dz16); end
        repeat (9) @(negedge clk);
        wr16(3'd3, 8'h20); wr16(3'd2, 8'h00);
        repeat (21) @(negedge clk);
        n_checks++; if (q16 !== 16'h4000 || done16 !== 1'b1) begin n_fail++; $display("FAIL snap_quot: got %h done %b want 4000 1", q16, done16); end
        @(negedge clk);
    endtask

    task automatic test_restart;
        wr16(3'd2, 8'h00); wr16(3'd3, 8'h80); wr16(3'd1, 8'h40); wr16(3'd0, 8'h00);
        repeat (9) @(negedge clk);
        wr16(3'd3, 8'h20); wr16(3'd2, 8'h00);
        repeat (7) @(negedge clk);
        wr16(3'd1, 8'h10); wr16(3'd0, 8'h00);
        n_checks++; if (busy16 !== 1'b1 || q16 !== 16'h0) begin n_fail++; $display("FAIL restart_start: busy %b q %h want 1 0000", busy16, q16); end
        repeat (31) @(negedge clk);
        n_checks++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL restart_early: done %b want 0", done16); end
        @(negedge clk);
        n_checks++; if (done16 !== 1'b1 || q16 !== 16'h4002) begin n_fail++; $display("FAIL restart_result: done %b q %h want 1 4002", done16, q16); end
        @(negedge clk);
    endtask

    task automatic test_out_of_range;
        wr16(3'd6, 8'hFF);
        rd16(3'd5, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_rd5: got %h want 00", rd); end
        rd16(3'd7, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL oor_rd7: got %h want 00", rd); end
        rd16(3'd4, rd);
        n_checks++; if (rd !== 8'h02) begin n_fail++; $display("FAIL oor_status: got %h want 02", rd); end
        @(negedge clk);
    endtask

    task automatic test_width8;
        wr8(2'd1, 8'h80); wr8(2'd0, 8'h40);
        repeat (7) @(negedge clk);
        n_checks++; if (done8 !== 1'b0 || busy8 !== 1'b1) begin n_fail++; $display("FAIL w8_early: done %b busy %b want 0 1", done8, busy8); end
        @(negedge clk);
        n_checks++; if (done8 !== 1'b1 || q8 !== 8'h40) begin n_fail++; $display("FAIL w8_result: done %b q %h want 1 40", done8, q8); end
        b8.rd_addr = 2'd1; #1;
        n_checks++; if (b8.rd_data !== 8'h00) begin n_fail++; $display("FAIL w8_residue: got %h want 00", b8.rd_data); end
        b8.rd_addr = 2'd2; #1;
        n_checks++; if (b8.rd_data !== 8'h02) begin n_fail++; $display("FAIL w8_status: got %h want 02", b8.rd_data); end
        @(negedge clk);
    endtask

    task automatic test_width32;
        wr32(4'd4, 8'h00); wr32(4'd5, 8'h00); wr32(4'd6, 8'h00); wr32(4'd7, 8'h80);
        wr32(4'd3, 8'h40); wr32(4'd2, 8'h00); wr32(4'd1, 8'h00); wr32(4'd0, 8'h00);
        repeat (127) @(negedge clk);
        n_checks++; if (done32 !== 1'b0 || busy32 !== 1'b1) begin n_fail++; $display("FAIL w32_early: done %b busy %b want 0 1", done32, busy32); end
        @(negedge clk);
        n_checks++; if (done32 !== 1'b1 || q32 !== 32'h40000000) begin n_fail++; $display("FAIL w32_result: done %b q %h want 1 40000000", done32, q32); end
        b32.rd_addr = 4'd8; #1;
        n_checks++; if (b32.rd_data !== 8'h02) begin n_fail++; $display("FAIL w32_status: got %h want 02", b32.rd_data); end
        @(negedge clk);
    endtask

    task automatic test_midrun_reset;
        wr16(3'd2, 8'h00); wr16(3'd3, 8'h00); wr16(3'd1, 8'h00); wr16(3'd0, 8'h01);
        repeat (14) @(negedge clk);
        n_checks++; if (q16 !== 16'h007F || dz16 !== 1'b1) begin n_fail++; $display("FAIL mrst_before: q %h dz %b want 007f 1", q16, dz16); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (q16 !== 16'h0 || {busy16, done16, dz16} !== 3'b000) begin n_fail++; $display("FAIL mrst_async: q %h flags %b want 0000 000", q16, {busy16, done16, dz16}); end
        rd16(3'd2, rd);
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL mrst_residue: got %h want 00", rd); end
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        n_checks++; if (done16 !== 1'b0 || busy16 !== 1'b0 || q16 !== 16'h0) begin n_fail++; $display("FAIL mrst_after: done %b busy %b q %h want 0 0 0000", done16, busy16, q16); end
    endtask

    initial begin
        rst = 1'b1;
        b16.wr_en = 1'b0; b16.wr_addr = '0; b16.cpu_data_in = '0; b16.rd_addr = '0;
        b8.wr_en  = 1'b0; b8.wr_addr  = '0; b8.cpu_data_in  = '0; b8.rd_addr  = '0;
        b32.wr_en = 1'b0; b32.wr_addr = '0; b32.cpu_data_in = '0; b32.rd_addr = '0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_equal();
        test_div_zero();
        test_snapshot();
        test_restart();
        test_out_of_range();
        test_width8();
        test_width32();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
